// File: rtl/reg_scoreboard_pkg.sv
// Shared sizing, types and helpers for the register pending-write scoreboard.
// Every count is a small per-register number of writes issued but not yet retired.
package reg_scoreboard_pkg;

    localparam int NUM_REGS  = 32;
    localparam int REG_IDX_W = 5;
    localparam int CNT_W     = 2;
    localparam logic [CNT_W-1:0] CNT_MAX = 2'd3;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [CNT_W-1:0]     cnt_t;

    // True when an enabled port targets register r; x0 is never tracked.
    function automatic logic hits(input logic en, input reg_idx_t idx, input reg_idx_t r);
        return en && (idx != '0) && (idx == r);
    endfunction

endpackage

// File: rtl/sb_counter.sv
// Pending-write counter for one register: +inc, -dec per cycle, clamped to 0..CNT_MAX.
// clamp flags a net release that exceeded the stored count.
module sb_counter
    import reg_scoreboard_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic [1:0] dec,
    output cnt_t       count,
    output cnt_t       count_next,
    output logic       clamp
);

    logic [CNT_W:0] up;
    logic [CNT_W:0] diff;

    always_comb begin
        up         = {1'b0, count} + {{CNT_W{1'b0}}, inc};
        diff       = up - {1'b0, dec};
        clamp      = 1'b0;
        count_next = diff[CNT_W-1:0];
        if (up < {1'b0, dec}) begin
            count_next = '0;
            clamp      = 1'b1;
        end else if (diff > {1'b0, CNT_MAX}) begin
            count_next = CNT_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks in-flight writes to x1..x31 and holds decode back on
// source hazards or a saturated destination counter.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           issue_valid,
    input  logic           issue_writes,
    input  logic [4:0]     issue_rd,
    input  logic [4:0]     rs1,
    input  logic [4:0]     rs2,
    input  logic           use_rs1,
    input  logic           use_rs2,
    input  logic           RegWrite,
    input  logic [4:0]     rd_w,
    input  logic           kill_valid,
    input  logic [4:0]     kill_rd,
    output logic           stall,
    output logic           issue_fire,
    output logic           pending_any,
    output logic           underflow_err
);

    // Handshake: decode offers an instruction with issue_valid; it is taken
    // (issue_fire) in any cycle where stall is low. stall is a pure function of
    // the current counts and this cycle's inputs, and is never high without issue_valid.

    cnt_t                 cnt_all   [NUM_REGS];
    cnt_t                 cnt_next  [1:NUM_REGS-1];
    logic                 inc_vec   [1:NUM_REGS-1];
    logic [1:0]           dec_cnt   [1:NUM_REGS-1];
    logic [NUM_REGS-1:1]  clamp_vec;

    logic rs1_hazard;
    logic rs2_hazard;
    logic dest_full;
    logic any_next;

    assign cnt_all[0] = '0;

    genvar g;
    generate
        for (g = 1; g < NUM_REGS; g++) begin : g_cnt
            sb_counter u_cnt (
                .clk        (clk),
                .rst        (rst),
                .inc        (inc_vec[g]),
                .dec        (dec_cnt[g]),
                .count      (cnt_all[g]),
                .count_next (cnt_next[g]),
                .clamp      (clamp_vec[g])
            );
        end
    endgenerate

    // A count of exactly 1 with the retiring write in this cycle is not a hazard:
    // the register file is written on the falling edge, before the source is read.
    always_comb begin
        rs1_hazard = use_rs1 && (rs1 != '0) && (cnt_all[rs1] != '0)
                     && !((cnt_all[rs1] == 2'd1) && RegWrite && (rd_w == rs1));
        rs2_hazard = use_rs2 && (rs2 != '0) && (cnt_all[rs2] != '0)
                     && !((cnt_all[rs2] == 2'd1) && RegWrite && (rd_w == rs2));
        dest_full  = issue_writes && (issue_rd != '0) && (cnt_all[issue_rd] == CNT_MAX)
                     && !(hits(RegWrite, rd_w, issue_rd) || hits(kill_valid, kill_rd, issue_rd));
        stall      = issue_valid && (rs1_hazard || rs2_hazard || dest_full);
        issue_fire = issue_valid && !stall;
    end

    always_comb begin
        for (int i = 1; i < NUM_REGS; i++) begin
            inc_vec[i] = issue_fire && hits(issue_writes, issue_rd, reg_idx_t'(i));
            dec_cnt[i] = {1'b0, hits(RegWrite, rd_w, reg_idx_t'(i))}
                       + {1'b0, hits(kill_valid, kill_rd, reg_idx_t'(i))};
        end
    end

    always_comb begin
        any_next = 1'b0;
        for (int i = 1; i < NUM_REGS; i++) begin
            any_next = any_next | (cnt_next[i] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_any   <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            pending_any   <= any_next;
            underflow_err <= underflow_err | (|clamp_vec);
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed scenarios followed by random
// traffic, all compared against a per-register integer count model.
module tb_reg_scoreboard;

    logic       clk;
    logic       rst;
    logic       issue_valid;
    logic       issue_writes;
    logic [4:0] issue_rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use_rs1;
    logic       use_rs2;
    logic       RegWrite;
    logic [4:0] rd_w;
    logic       kill_valid;
    logic [4:0] kill_rd;
    logic       stall;
    logic       issue_fire;
    logic       pending_any;
    logic       underflow_err;

    int error_count = 0;
    int check_count = 0;

    int         mc [32];
    logic       m_uf;
    logic [1:0] exp_q [$];
    logic       last_stall;
    logic       obs_pend;
    logic       obs_uf;

    reg_scoreboard dut (
        .clk           (clk),
        .rst           (rst),
        .issue_valid   (issue_valid),
        .issue_writes  (issue_writes),
        .issue_rd      (issue_rd),
        .rs1           (rs1),
        .rs2           (rs2),
        .use_rs1       (use_rs1),
        .use_rs2       (use_rs2),
        .RegWrite      (RegWrite),
        .rd_w          (rd_w),
        .kill_valid    (kill_valid),
        .kill_rd       (kill_rd),
        .stall         (stall),
        .issue_fire    (issue_fire),
        .pending_any   (pending_any),
        .underflow_err (underflow_err)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        rst = 1'b1; issue_valid = 1'b0; issue_writes = 1'b0; issue_rd = '0;
        rs1 = '0; rs2 = '0; use_rs1 = 1'b0; use_rs2 = 1'b0;
        RegWrite = 1'b0; rd_w = '0; kill_valid = 1'b0; kill_rd = '0;
        for (int i = 0; i < 32; i++) mc[i] = 0;
        m_uf = 1'b0;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_count++;
        if (obs !== exp) begin
            error_count++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference rules: a used nonzero source with pending writes blocks, unless the
    // only pending write retires this very cycle; a full destination blocks unless released.
    function automatic logic model_stall();
        logic blk;
        blk = 1'b0;
        if (use_rs1 && rs1 != 0 && mc[rs1] > 0 && !(mc[rs1] == 1 && RegWrite && rd_w == rs1)) blk = 1'b1;
        if (use_rs2 && rs2 != 0 && mc[rs2] > 0 && !(mc[rs2] == 1 && RegWrite && rd_w == rs2)) blk = 1'b1;
        if (issue_writes && issue_rd != 0 && mc[issue_rd] == 3
            && !((RegWrite && rd_w == issue_rd) || (kill_valid && kill_rd == issue_rd))) blk = 1'b1;
        return issue_valid && blk;
    endfunction

    task automatic model_update(input logic fired);
        int v;
        logic any;
        if (rst) begin
            for (int r = 0; r < 32; r++) mc[r] = 0;
            m_uf = 1'b0;
        end else begin
            for (int r = 1; r < 32; r++) begin
                v = mc[r];
                if (fired && issue_writes && issue_rd == r) v = v + 1;
                if (RegWrite && rd_w == r) v = v - 1;
                if (kill_valid && kill_rd == r) v = v - 1;
                if (v < 0) begin
                    v = 0;
                    m_uf = 1'b1;
                end
                if (v > 3) v = 3;
                mc[r] = v;
            end
        end
        any = 1'b0;
        for (int r = 1; r < 32; r++) if (mc[r] != 0) any = 1'b1;
        exp_q.push_back({m_uf, any});
    endtask

    task automatic pop_check();
        logic [1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            obs_pend = pending_any;
            obs_uf   = underflow_err;
            check_val("pending_any", {31'd0, pending_any}, {31'd0, e[0]});
            check_val("underflow_err", {31'd0, underflow_err}, {31'd0, e[1]});
        end
    endtask

    // driver: one cycle of stimulus, checked before and after the edge
    task automatic step(input logic r, input logic iv, input logic iw, input logic [4:0] ird,
                        input logic [4:0] s1, input logic u1, input logic [4:0] s2, input logic u2,
                        input logic rw, input logic [4:0] rdw, input logic kv, input logic [4:0] krd);
        logic es;
        @(negedge clk);
        pop_check();
        rst = r; issue_valid = iv; issue_writes = iw; issue_rd = ird;
        rs1 = s1; use_rs1 = u1; rs2 = s2; use_rs2 = u2;
        RegWrite = rw; rd_w = rdw; kill_valid = kv; kill_rd = krd;
        #1;
        es = model_stall();
        check_val("stall", {31'd0, stall}, {31'd0, es});
        check_val("issue_fire", {31'd0, issue_fire}, {31'd0, iv && !es});
        last_stall = stall;
        model_update(iv && !es);
        @(posedge clk);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic logic [4:0] rand_idx();
        return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
    endfunction

    initial begin
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        check_val("reset_pending", {31'd0, obs_pend}, 32'd0);

        // writer x5, dependent reader held until writeback
        step(0, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0);
        check_val("raw_stall", {31'd0, last_stall}, 32'd1);
        step(0, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0);
        check_val("raw_stall_hold", {31'd0, last_stall}, 32'd1);
        step(0, 1, 0, 0, 5, 1, 0, 0, 1, 5, 0, 0);
        check_val("raw_wb_release", {31'd0, last_stall}, 32'd0);

        // x7 saturation
        repeat (3) step(0, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
        check_val("sat_stall", {31'd0, last_stall}, 32'd1);
        step(0, 1, 1, 7, 0, 0, 0, 0, 1, 7, 0, 0);
        check_val("sat_wb_release", {31'd0, last_stall}, 32'd0);
        step(0, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
        check_val("sat_still_full", {31'd0, last_stall}, 32'd1);
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0);

        // x9 issue and writeback together
        step(0, 1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 9, 0, 0, 0, 0, 1, 9, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0);
        check_val("net_zero_pending", {31'd0, obs_pend}, 32'd1);
        idle();
        check_val("drained_pending", {31'd0, obs_pend}, 32'd0);

        // underflow on x3, sticky until reset
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0);
        idle();
        check_val("underflow_set", {31'd0, obs_uf}, 32'd1);
        repeat (3) idle();
        check_val("underflow_sticky", {31'd0, obs_uf}, 32'd1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // x0 is never tracked
        step(0, 1, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        check_val("x0_no_stall", {31'd0, last_stall}, 32'd0);
        idle();
        check_val("x0_no_pending", {31'd0, obs_pend}, 32'd0);

        // reset with live counts and a simultaneous issue, then a stale writeback
        step(0, 1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 4, 0, 0, 0, 0, 1, 6, 1, 4);
        idle();
        check_val("rst_clears_pending", {31'd0, obs_pend}, 32'd0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0);
        idle();
        check_val("stale_wb_underflow", {31'd0, obs_uf}, 32'd1);
        step(0, 1, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0);
        check_val("rst_no_hazard", {31'd0, last_stall}, 32'd0);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0), rand_idx(),
                 rand_idx(), $urandom_range(0, 1) == 1, rand_idx(), $urandom_range(0, 1) == 1,
                 ($urandom_range(0, 2) == 0), rand_idx(),
                 ($urandom_range(0, 7) == 0), rand_idx());
        end

        idle();
        @(negedge clk);
        pop_check();

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
